// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front-end: opcode constants used by the
// pre-decoder, FSM state encodings, queue entry layout and immediate helpers.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [1:0] RVC_QUAD_MASK = 2'b11;
  localparam logic [2:0] CJ_FUNCT3     = 3'b101;
  localparam logic [1:0] CJ_QUAD       = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            rvc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
  } fetch_entry_t;

  // Sign-extended JAL offset: imm[20|10:1|11|19:12] sits in inst[31:12].
  function automatic logic [XLEN-1:0] jal_offset(input logic [XLEN-1:0] d);
    return {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
  endfunction

  // Sign-extended C.J offset: imm[11|4|9:8|10|6|7|3:1|5] sits in inst[12:2].
  function automatic logic [XLEN-1:0] cj_offset(input logic [XLEN-1:0] d);
    return {{21{d[12]}}, d[12], d[8], d[10:9], d[6], d[7], d[2], d[11], d[5:3], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch stage's external handshakes:
//   ROB flush      : _clear, _clear_pc
//   memory port    : _mem_busy, _mem_req, _mem_addr, _mem_valid, _mem_data
//   consumer port  : _deq_valid, _deq_ready, _deq_inst, _deq_pc, _deq_rvc,
//                    _deq_pred_taken, _deq_pred_pc, _count
// master = the fetch queue, slave = its environment.
interface fetch_queue_if #(parameter int DEPTH = 8);
  import fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             _clear;
  logic [XLEN-1:0]  _clear_pc;
  logic             _mem_busy;
  logic             _mem_req;
  logic [XLEN-1:0]  _mem_addr;
  logic             _mem_valid;
  logic [XLEN-1:0]  _mem_data;
  logic             _deq_valid;
  logic             _deq_ready;
  logic [XLEN-1:0]  _deq_inst;
  logic [XLEN-1:0]  _deq_pc;
  logic             _deq_rvc;
  logic             _deq_pred_taken;
  logic [XLEN-1:0]  _deq_pred_pc;
  logic [CNT_W-1:0] _count;

  modport master (
    input  _clear, _clear_pc, _mem_busy, _mem_valid, _mem_data, _deq_ready,
    output _mem_req, _mem_addr, _deq_valid, _deq_inst, _deq_pc, _deq_rvc,
           _deq_pred_taken, _deq_pred_pc, _count
  );

  modport slave (
    output _clear, _clear_pc, _mem_busy, _mem_valid, _mem_data, _deq_ready,
    input  _mem_req, _mem_addr, _deq_valid, _deq_inst, _deq_pc, _deq_rvc,
           _deq_pred_taken, _deq_pred_pc, _count
  );

endinterface

// File: rtl/fetch_predecode.sv
// Combinational pre-decoder for one fetched word.
//   data       : raw word returned by memory
//   pc         : address the word was fetched from
//   rvc        : word holds a 16-bit compressed instruction
//   inst_norm  : instruction, compressed ones zero-extended from [15:0]
//   pred_taken : static prediction redirected the fetch (JAL / C.J)
//   next_pc    : address to fetch after this instruction
module fetch_predecode
  import fetch_pkg::*;
#(
  parameter bit RVC_EN      = 1'b1,
  parameter bit PREDICT_JAL = 1'b1
) (
  input  logic [XLEN-1:0] data,
  input  logic [XLEN-1:0] pc,
  output logic            rvc,
  output logic [XLEN-1:0] inst_norm,
  output logic            pred_taken,
  output logic [XLEN-1:0] next_pc
);

  logic            is_jal_s;
  logic            is_cj_s;
  logic [XLEN-1:0] step_s;

  // Classify the word and pick the sequential or predicted successor.
  always_comb begin
    rvc        = RVC_EN && (data[1:0] != RVC_QUAD_MASK);
    is_jal_s   = !rvc && (data[6:0] == OPC_JAL);
    is_cj_s    = rvc && (data[15:13] == CJ_FUNCT3) && (data[1:0] == CJ_QUAD);
    step_s     = rvc ? 32'd2 : 32'd4;
    inst_norm  = rvc ? {16'h0000, data[15:0]} : data;
    pred_taken = 1'b0;
    next_pc    = pc + step_s;
    if (PREDICT_JAL && is_jal_s) begin
      pred_taken = 1'b1;
      next_pc    = pc + jal_offset(data);
    end else if (PREDICT_JAL && is_cj_s) begin
      pred_taken = 1'b1;
      next_pc    = pc + cj_offset(data);
    end else begin
      pred_taken = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Front-end fetch stage: issues one instruction read at a time, pre-decodes
// the response and buffers it in a DEPTH-entry circular queue drained by a
// valid/ready consumer. A ROB flush empties the queue, reloads the PC and
// discards any response still in flight.
//   clk_in : clock          rst_in : synchronous active-high reset
//   rdy_in : global enable; low freezes every register and masks _mem_req
//   fq     : flush, memory and dequeue handshakes (fetch_queue_if.master)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter bit          RVC_EN      = 1'b1,
  parameter bit          PREDICT_JAL = 1'b1
) (
  input logic        clk_in,
  input logic        rst_in,
  input logic        rdy_in,
  fetch_queue_if.master fq
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_r;
  fetch_state_e     state_nxt_s;
  logic [XLEN-1:0]  pc_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  fetch_entry_t     store_r [DEPTH];

  logic             full_s;
  logic             issue_s;
  logic             enq_s;
  logic             deq_s;
  fetch_entry_t     entry_s;
  fetch_entry_t     head_s;

  logic             pd_rvc_s;
  logic [XLEN-1:0]  pd_inst_s;
  logic             pd_taken_s;
  logic [XLEN-1:0]  pd_next_pc_s;

  fetch_predecode #(
    .RVC_EN      (RVC_EN),
    .PREDICT_JAL (PREDICT_JAL)
  ) u_predecode (
    .data       (fq._mem_data),
    .pc         (pc_r),
    .rvc        (pd_rvc_s),
    .inst_norm  (pd_inst_s),
    .pred_taken (pd_taken_s),
    .next_pc    (pd_next_pc_s)
  );

  assign full_s = (count_r == CNT_W'(DEPTH));

  // Next-state and handshake decode; _clear overrides issue and enqueue.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    enq_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fq._clear && !full_s && !fq._mem_busy) begin
          issue_s     = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (fq._mem_valid) begin
          enq_s       = !fq._clear;
          state_nxt_s = IDLE;
        end else if (fq._clear) begin
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DROP: begin
        if (fq._mem_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    deq_s = (count_r != '0) && fq._deq_ready && !fq._clear;
  end

  // Entry assembled from the response; pc_r is still the fetch address here.
  always_comb begin
    entry_s.inst       = pd_inst_s;
    entry_s.pc         = pc_r;
    entry_s.rvc        = pd_rvc_s;
    entry_s.pred_taken = pd_taken_s;
    entry_s.pred_pc    = pd_next_pc_s;
    // Empty queue presents zeros instead of stale storage.
    if (count_r != '0) begin
      head_s = store_r[head_r];
    end else begin
      head_s = '0;
    end
  end

  // Control registers: FSM, PC, queue pointers and occupancy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (rdy_in) begin
      state_r <= state_nxt_s;
      if (fq._clear) begin
        pc_r    <= fq._clear_pc;
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= '0;
      end else begin
        if (enq_s) begin
          pc_r   <= pd_next_pc_s;
          tail_r <= tail_r + PTR_W'(1);
        end
        if (deq_s) begin
          head_r <= head_r + PTR_W'(1);
        end
        case ({enq_s, deq_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Queue storage; not reset because the head is masked while empty.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && enq_s) begin
      store_r[tail_r] <= entry_s;
    end
  end

  assign fq._mem_req        = issue_s && rdy_in && !rst_in;
  assign fq._mem_addr       = pc_r;
  assign fq._deq_valid      = (count_r != '0);
  assign fq._deq_inst       = head_s.inst;
  assign fq._deq_pc         = head_s.pc;
  assign fq._deq_rvc        = head_s.rvc;
  assign fq._deq_pred_taken = head_s.pred_taken;
  assign fq._deq_pred_pc    = head_s.pred_pc;
  assign fq._count          = count_r;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised front-end fetch stage: issues instruction reads to the memory controller, pre-decodes each returned word (RVC detect, JAL/C.J target prediction), and buffers {inst, pc, rvc, prediction} in a DEPTH-entry circular queue.
- The decoder/issue stage drains the queue through a valid/ready handshake.
- A ROB redirect flushes the queue and any in-flight fetch.
- Successor of the single-entry fetcher: adds configurable buffering, an explicit memory handshake FSM with drop-after-flush, and static jump prediction.

Parameters:
- DEPTH, 8, queue entries; power of two, ≥2.
- RESET_PC, 32'h0, PC loaded on reset.
- RVC_EN, 1, 1 = recognise 16-bit compressed instructions; 0 = every fetch is 32-bit, PC step 4.
- PREDICT_JAL, 1, 1 = JAL/C.J predicted taken and PC redirected at fetch; 0 = always sequential.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset
- rdy_in  in  1  global enable; low freezes all state
- _clear  in  1  ROB mispredict flush
- _clear_pc  in  32  redirect target, valid with _clear
- _mem_busy  in  1  memory controller cannot accept a request
- _mem_req  out  1  one-cycle fetch request pulse
- _mem_addr  out  32  fetch address, valid with _mem_req
- _mem_valid  in  1  one-cycle response pulse
- _mem_data  in  32  fetched word (halfword-aligned address supported)
- _deq_valid  out  1  queue head valid
- _deq_ready  in  1  consumer takes head this cycle
- _deq_inst  out  32  instruction; RVC entries are zero-extended [15:0]
- _deq_pc  out  32  instruction address
- _deq_rvc  out  1  head is 16-bit
- _deq_pred_taken  out  1  fetch redirected after this instruction
- _deq_pred_pc  out  32  PC fetched after this instruction
- _count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset is synchronous and active-high on rst_in. It sets pc=RESET_PC, head=tail=count=0, state IDLE. All outputs are 0, except _mem_addr, which follows pc.
- FSM states: IDLE, WAIT, DROP.
  - IDLE: if !_clear && count<DEPTH && !_mem_busy, assert _mem_req with _mem_addr=pc, then go to WAIT. Otherwise stay in IDLE.
  - WAIT: on _mem_valid, enqueue one entry, update pc to next_pc, go to IDLE. The earliest next request is the following cycle.
  - DROP: on _mem_valid, discard the data and go to IDLE.
- At most one request is outstanding, so the count<DEPTH check at issue guarantees space when the response arrives.
- Pre-decode of _mem_data:
  - rvc = RVC_EN && data[1:0]!=2'b11.
  - step = rvc ? 2 : 4.
  - JAL: !rvc && data[6:0]==7'b1101111. Target = pc + sext(J-imm).
  - C.J: rvc && data[15:13]==3'b101 && data[1:0]==2'b01. Target = pc + sext(CJ-imm).
  - With PREDICT_JAL and a jump hit: next_pc = target, pred_taken = 1. Otherwise next_pc = pc+step, pred_taken = 0.
  - All arithmetic is 32-bit modulo 2^32.
- Dequeue: _deq_valid = (count!=0). Head fields are driven combinationally from the head entry. A transfer occurs when _deq_valid && _deq_ready. The head pointer wraps modulo DEPTH.
- Simultaneous enqueue and dequeue: count is unchanged. This is legal at count==DEPTH only if a response is pending; by construction that never happens.
- _clear has priority over everything:
  - Flushes the queue (head=tail=count=0) and loads pc from _clear_pc.
  - In WAIT without _mem_valid: go to DROP.
  - In WAIT with _mem_valid the same cycle: drop the response, go to IDLE.
  - In DROP: stay in DROP; a same-cycle _mem_valid ends the DROP and goes to IDLE.
  - In IDLE: no request is issued that cycle.
  - A dequeue coincident with _clear is void.
- rdy_in low: no register updates, _mem_req=0. The memory controller shares rdy_in and returns no data while it is low.
- _mem_busy rising while in WAIT has no effect; the response is still awaited.

Decomposition:
- Shared package fetch_pkg holds:
  - OPC_JAL=7'b1101111, RVC_QUAD_MASK=2'b11, CJ_FUNCT3=3'b101, CJ_QUAD=2'b01
  - FSM state encodings IDLE/WAIT/DROP
  - entry field widths (XLEN=32)
- Sub-module fetch_predecode: combinational; inputs data and pc; outputs rvc, inst_norm, pred_taken, next_pc.
- Queue storage and pointers stay in fetch_queue.

Test Plan:
1. Reset, memory always responds next cycle with 32'h00000013 (addi), _deq_ready=0 → requests at 0,4,…,0x1C; count reaches 8; no further _mem_req while full.
2. Word 32'h0000006F at pc 0x10 (jal x0,0), PREDICT_JAL=1 → entry pred_taken=1, pred_pc=0x10; next _mem_addr=0x10. Word 32'h0080006F (jal +8) → next fetch 0x18.
3. RVC_EN=1, data 32'hxxxx4501 (c.li) at 0x0 → _deq_rvc=1, _deq_inst=32'h00004501, next fetch 0x2. C.J 16'hA001 → pred_taken=1, next fetch equals the same pc.
4. _clear with _clear_pc=0x200 while in WAIT, response arrives 3 cycles later → response discarded, count=0, next _mem_addr=0x200.
5. _clear coincident with _mem_valid and _deq_ready at count=3 → count=0, no enqueue, next request to _clear_pc the following cycle.
6. rdy_in held low 5 cycles with count=4 and _deq_ready=1 → count, pc and state unchanged; _mem_req=0; resumes identically afterwards.
